matrix_op_sequencer: RTL and testbench
======================================

MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 Parameter RD_LAT, default 2: RAM read latency in clock edges, from the edge that captures mem_addr to registered mem_rdata valid.
REQ-002 Parameter ALU_LAT, default 1: clock edges from mat_a/mat_b stable to alu_result valid.
REQ-003 One clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to accept instr; sampled only in IDLE.
REQ-007 instr  input  32  instruction: [2:0] opcode, [10:3] addr_a, [18:11] addr_b, [26:19] addr_c, [31:27] reserved (ignored).
REQ-008 busy  output  1  high while an instruction is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 error  output  1  illegal opcode flag; sticky until the next accepted start.
REQ-011 mem_addr  output  8  address to the 256-bit single-port RAM.
REQ-012 mem_wren  output  1  RAM write enable.
REQ-013 mem_wdata  output  256  RAM write data (registered ALU result).
REQ-014 mem_rdata  input  256  RAM read data.
REQ-015 alu_op  output  3  opcode presented to the matrix ALU.
REQ-016 mat_a  output  256  registered operand A.
REQ-017 mat_b  output  256  registered operand B.
REQ-018 alu_result  input  256  ALU output.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 Opcodes SHALL be decoded as follows:
- 000 ADD, 001 SUB, 010 MUL, 011 SCALAR (binary: read A and B).
- 100 TRANSPOSE, 101 NEGATE (unary: read A only).
- 110 and 111 illegal.
REQ-021 FSM states SHALL be IDLE, RD_A, RD_B, EXEC, WRITE, DONE.
REQ-022 Accept: in IDLE with start=1 at edge E0, the block SHALL latch instr, set alu_op=opcode, set busy=1, clear error, enter RD_A, and drive mem_addr=addr_a.
REQ-023 RD_A SHALL hold mem_addr for RD_A timing and capture mem_rdata into mat_a at edge E0+RD_LAT+1.
- Binary op: enter RD_B with mem_addr=addr_b.
- Unary op: set mat_b=0 and enter EXEC.
REQ-024 RD_B SHALL capture mem_rdata into mat_b RD_LAT+1 edges after entering RD_B, then enter EXEC.
REQ-025 EXEC SHALL wait ALU_LAT edges, then latch alu_result into mem_wdata, drive mem_addr=addr_c and mem_wren=1, and enter WRITE.
REQ-026 WRITE SHALL last exactly one cycle; at its end: mem_wren=0, busy=0, done=1, state DONE.
REQ-027 DONE SHALL last one cycle with done=1; at its end: done=0, mem_addr=0, state IDLE.
REQ-028 In DONE, start=1 SHALL be accepted as in REQ-022; done is still 0 on the following cycle.
REQ-029 Latency with defaults: done high in the cycle after edge E0+8 (binary) and E0+5 (unary).
- General binary: done after edge 2*(RD_LAT+1)+ALU_LAT+1.
- General unary: done after edge (RD_LAT+1)+ALU_LAT+1.
REQ-030 Illegal opcode accepted at E0:
- After E0: error=1, done=1 for one cycle, busy=0.
- No mem_wren and no mem_addr change.
- Return to IDLE.
REQ-031 start while busy=1 SHALL be ignored; the instruction is not queued.
REQ-032 mem_wren SHALL be high for exactly one cycle per legal instruction and never outside WRITE.
REQ-033 addr_c equal to addr_a or addr_b SHALL be legal; reads complete before the write.
REQ-034 Instr changes after acceptance SHALL have no effect until the next accept.

Reset
REQ-035 reset=1 at any edge SHALL force:
- state IDLE;
- busy, done, error, mem_wren = 0;
- mem_addr = 0; alu_op = 0;
- mem_wdata, mat_a, mat_b = 0.
REQ-036 Reset mid-operation, including in WRITE, SHALL abort the instruction with mem_wren=0 from the next cycle; no done pulse.
REQ-037 reset SHALL take priority over a simultaneous start.

Verification
REQ-038 ADD: RAM[1]=all 0x01 bytes, RAM[2]=all 0x02 bytes, instr addr_a=1, addr_b=2, addr_c=3, opcode 000, start at E0 -> one mem_wren pulse at addr 3, RAM[3]=all 0x03 bytes, done after E0+8.
REQ-039 SUB with addr_c=1: RAM[1]=0x05 bytes, RAM[2]=0x02 bytes -> RAM[1]=0x03 bytes, RAM[2] unchanged.
REQ-040 NEGATE opcode 101, addr_a=4, addr_c=5 -> mem_addr never equals addr_b, mat_b=0, done after E0+5.
REQ-041 Opcode 111 -> error=1 and done=1 in the cycle after E0, mem_wren never asserted; next legal start clears error.
REQ-042 start pulsed in every cycle during an ADD -> exactly one write and one done; start held through DONE starts the second op back-to-back.
REQ-043 reset asserted in the WRITE cycle -> target RAM word unchanged or fully written (single edge), all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/matrix_op_sequencer_if.sv
// rtl/matrix_op_sequencer_if.sv - command, RAM and ALU signal bundle for the matrix op sequencer
interface matrix_op_sequencer_if;
  logic         start;
  logic [31:0]  instr;
  logic         busy;
  logic         done;
  logic         error;
  logic [7:0]   mem_addr;
  logic         mem_wren;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic [2:0]   alu_op;
  logic [255:0] mat_a;
  logic [255:0] mat_b;
  logic [255:0] alu_result;

  // Environment side: issues instructions, owns the RAM and the ALU.
  modport master (
    output start, instr, mem_rdata, alu_result,
    input  busy, done, error, mem_addr, mem_wren, mem_wdata, alu_op, mat_a, mat_b
  );

  // Sequencer side.
  modport slave (
    input  start, instr, mem_rdata, alu_result,
    output busy, done, error, mem_addr, mem_wren, mem_wdata, alu_op, mat_a, mat_b
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - fetches operands, runs the matrix ALU and writes the result back
module matrix_op_sequencer #(
  parameter int RD_LAT  = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_op_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A zero ALU latency still needs one edge to latch the result.
  localparam int         ALU_WAIT = (ALU_LAT < 1) ? 1 : ALU_LAT;
  localparam logic [7:0] RD_LAST  = 8'(RD_LAT);
  localparam logic [7:0] ALU_LAST = 8'(ALU_WAIT - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   addr_b_q, addr_b_d;
  logic [7:0]   addr_c_q, addr_c_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         error_q, error_d;
  logic [7:0]   mem_addr_q, mem_addr_d;
  logic         mem_wren_q, mem_wren_d;
  logic [255:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [255:0] mat_a_q, mat_a_d;
  logic [255:0] mat_b_q, mat_b_d;

  logic [2:0]   opcode;
  logic         illegal;
  logic         accept;
  logic         instr_unused;

  assign opcode       = bus.instr[2:0];
  assign illegal      = (opcode == 3'd6) || (opcode == 3'd7);
  assign accept       = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign instr_unused = ^bus.instr[31:27];

  // State and output registers; reset clears everything and beats a simultaneous start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
      alu_op_q    <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
      alu_op_q    <= alu_op_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
    end
  end

  // Next-state and next-output logic; a new instruction may be accepted from IDLE or DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_b_d    = addr_b_q;
    addr_c_d    = addr_c_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    mem_addr_d  = mem_addr_q;
    mem_wren_d  = mem_wren_q;
    mem_wdata_d = mem_wdata_q;
    alu_op_d    = alu_op_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;

    case (state_q)
      IDLE: begin
      end
      RD_A: begin
        if (cnt_q == RD_LAST) begin
          mat_a_d = bus.mem_rdata;
          cnt_d   = '0;
          // Opcodes 100/101 are unary: B is forced to zero and never fetched.
          if (alu_op_q[2]) begin
            mat_b_d = '0;
            state_d = EXEC;
          end else begin
            mem_addr_d = addr_b_q;
            state_d    = RD_B;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_B: begin
        if (cnt_q == RD_LAST) begin
          mat_b_d = bus.mem_rdata;
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EXEC: begin
        if (cnt_q == ALU_LAST) begin
          mem_wdata_d = bus.alu_result;
          mem_addr_d  = addr_c_q;
          mem_wren_d  = 1'b1;
          cnt_d       = '0;
          state_d     = WRITE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WRITE: begin
        mem_wren_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        done_d     = 1'b0;
        mem_addr_d = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Later instr changes are ignored because only the latched fields are used after this.
    if (accept) begin
      alu_op_d = opcode;
      addr_b_d = bus.instr[18:11];
      addr_c_d = bus.instr[26:19];
      cnt_d    = '0;
      error_d  = illegal;
      if (illegal) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        busy_d     = 1'b1;
        done_d     = 1'b0;
        mem_addr_d = bus.instr[10:3];
        state_d    = RD_A;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.mat_a     = mat_a_q;
  assign bus.mat_b     = mat_b_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb/tb_matrix_op_sequencer.sv - scoreboard bench for matrix_op_sequencer with RAM and ALU models
module tb_matrix_op_sequencer;

  localparam int RD_LAT  = 2;
  localparam int ALU_LAT = 1;

  typedef struct {
    logic         err;
    logic         unary;
    logic         abort;
    logic [7:0]   wr_addr;
    logic [255:0] wr_data;
    logic         forbid_en;
    logic [7:0]   forbid;
    int           done_cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [255:0] ram     [256];
  logic [255:0] ref_ram [256];
  logic [7:0]   addr_pipe [RD_LAT];
  exp_t         sb_q [$];

  matrix_op_sequencer_if ifc ();

  matrix_op_sequencer #(.RD_LAT(RD_LAT), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment ALU: byte-lane matrix ops; unary ops fold B in so a non-zero mat_b is visible.
  function automatic logic [255:0] alu_fn(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        3'd0: r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        3'd1: r[i*8 +: 8] = a[i*8 +: 8] - b[i*8 +: 8];
        3'd2: r[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8];
        3'd3: r[i*8 +: 8] = a[i*8 +: 8] * b[7:0];
        3'd4: r[i*8 +: 8] = a[(31-i)*8 +: 8] ^ b[i*8 +: 8];
        3'd5: r[i*8 +: 8] = (8'd0 - a[i*8 +: 8]) ^ b[i*8 +: 8];
        default: r[i*8 +: 8] = 8'h00;
      endcase
    end
    return r;
  endfunction

  assign ifc.alu_result = alu_fn(ifc.alu_op, ifc.mat_a, ifc.mat_b);

  // Environment RAM: address pipeline of RD_LAT edges, single-edge writes.
  always @(posedge clk) begin
    addr_pipe[0] <= ifc.mem_addr;
    for (int i = RD_LAT - 1; i > 0; i--) addr_pipe[i] <= addr_pipe[i-1];
    if (ifc.mem_wren) ram[ifc.mem_addr] <= ifc.mem_wdata;
  end

  assign ifc.mem_rdata = ram[addr_pipe[RD_LAT-1]];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {5'($urandom), c, b, a, op};
  endfunction

  // Reference model: evaluates the instruction against the model RAM and predicts the response.
  function automatic exp_t model(input logic [31:0] ins, input int e0);
    exp_t         e;
    logic [2:0]   op;
    logic [7:0]   a, b, c;
    logic [255:0] va, vb;
    op = ins[2:0];
    a  = ins[10:3];
    b  = ins[18:11];
    c  = ins[26:19];
    e.err       = (op == 3'd6) || (op == 3'd7);
    e.unary     = (op == 3'd4) || (op == 3'd5);
    e.abort     = 1'b0;
    e.wr_addr   = c;
    e.forbid    = b;
    e.forbid_en = e.unary && (b != a) && (b != c);
    if (e.err) begin
      e.wr_data  = '0;
      e.done_cyc = e0;
    end else begin
      va = ref_ram[a];
      vb = e.unary ? 256'd0 : ref_ram[b];
      e.wr_data  = alu_fn(op, va, vb);
      ref_ram[c] = e.wr_data;
      e.done_cyc = e0 + (e.unary ? (RD_LAT + 1) + ALU_LAT + 1 : 2 * (RD_LAT + 1) + ALU_LAT + 1);
    end
    return e;
  endfunction

  task automatic set_word(input logic [7:0] a, input logic [255:0] v);
    ram[a]     <= v;
    ref_ram[a]  = v;
  endtask

  // Issue at a negedge where the DUT is in IDLE or DONE; returns at the negedge of its DONE cycle
  // (or of its WRITE cycle when abort_it is set).
  task automatic run_op(input logic [31:0] ins, input bit spam, input bit abort_it);
    exp_t e;
    e       = model(ins, cyc + 1);
    e.abort = abort_it;
    sb_q.push_back(e);
    ifc.start = 1'b1;
    ifc.instr = ins;
    @(negedge clk);
    while (cyc < e.done_cyc) begin
      if (abort_it && (cyc == e.done_cyc - 1)) break;
      ifc.start = spam;
      ifc.instr = $urandom;
      @(negedge clk);
    end
    ifc.start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      256'(ifc.busy),     256'd0);
    chk({tag, "_done"},      256'(ifc.done),     256'd0);
    chk({tag, "_error"},     256'(ifc.error),    256'd0);
    chk({tag, "_mem_wren"},  256'(ifc.mem_wren), 256'd0);
    chk({tag, "_mem_addr"},  256'(ifc.mem_addr), 256'd0);
    chk({tag, "_alu_op"},    256'(ifc.alu_op),   256'd0);
    chk({tag, "_mem_wdata"}, ifc.mem_wdata,      256'd0);
    chk({tag, "_mat_a"},     ifc.mat_a,          256'd0);
    chk({tag, "_mat_b"},     ifc.mat_b,          256'd0);
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks writes against the front entry.
  initial begin : monitor
    int   wr_cnt;
    exp_t e;
    wr_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        if (sb_q.size() > 0 && sb_q[0].abort) e = sb_q.pop_front();
        wr_cnt = 0;
      end else begin
        if (ifc.mem_wren) begin
          wr_cnt++;
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_unexpected: write to addr %0d with no pending instruction", ifc.mem_addr);
          end else begin
            chk("wr_addr", 256'(ifc.mem_addr), 256'(sb_q[0].wr_addr));
            chk("wr_data", ifc.mem_wdata, sb_q[0].wr_data);
            if (sb_q[0].unary) chk("unary_mat_b", ifc.mat_b, 256'd0);
          end
        end
        if (ifc.busy && sb_q.size() > 0 && sb_q[0].forbid_en)
          chk("unary_addr_b_unused", 256'(ifc.mem_addr == sb_q[0].forbid), 256'd0);
        if (ifc.done) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_unexpected: done at cycle %0d with no pending instruction", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("done_cycle", 256'(cyc), 256'(e.done_cyc));
            chk("done_error", 256'(ifc.error), 256'(e.err));
            chk("done_busy", 256'(ifc.busy), 256'd0);
            chk("write_count", 256'(wr_cnt), e.err ? 256'd0 : 256'd1);
          end
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin : driver
    logic [255:0] v;
    logic [2:0]   op;
    bit           spam, b2b;
    int           bad;
    reset     = 1'b1;
    ifc.start = 1'b0;
    ifc.instr = '0;
    for (int i = 0; i < 256; i++) begin
      v = {8{$urandom}};
      set_word(8'(i), v);
    end
    repeat (2) @(negedge clk);
    // Start during reset must lose to reset.
    ifc.start = 1'b1;
    ifc.instr = mk(3'd0, 8'd1, 8'd2, 8'd3);
    @(negedge clk);
    chk_zero("reset");
    reset     = 1'b0;
    ifc.start = 1'b0;
    @(negedge clk);
    chk("reset_prio_idle", 256'(ifc.busy), 256'd0);

    // ADD 1+2 -> 3
    set_word(8'd1, {32{8'h01}});
    set_word(8'd2, {32{8'h02}});
    @(negedge clk);
    run_op(mk(3'd0, 8'd1, 8'd2, 8'd3), 1'b0, 1'b0);
    chk("add_ram3", ram[3], {32{8'h03}});
    @(negedge clk);

    // SUB writing over operand A
    set_word(8'd1, {32{8'h05}});
    @(negedge clk);
    run_op(mk(3'd1, 8'd1, 8'd2, 8'd1), 1'b0, 1'b0);
    chk("sub_ram1", ram[1], {32{8'h03}});
    chk("sub_ram2", ram[2], {32{8'h02}});
    @(negedge clk);

    // NEGATE: B never fetched
    run_op(mk(3'd5, 8'd4, 8'd9, 8'd5), 1'b0, 1'b0);
    @(negedge clk);

    // Illegal opcode from IDLE: error sticky until next accept
    run_op(mk(3'd7, 8'd10, 8'd11, 8'd12), 1'b0, 1'b0);
    chk("illegal_mem_addr", 256'(ifc.mem_addr), 256'd0);
    chk("illegal_error", 256'(ifc.error), 256'd1);
    chk("illegal_busy", 256'(ifc.busy), 256'd0);
    repeat (3) @(negedge clk);
    chk("illegal_error_sticky", 256'(ifc.error), 256'd1);
    chk("illegal_no_wren", 256'(ifc.mem_wren), 256'd0);
    run_op(mk(3'd6, 8'd1, 8'd2, 8'd3), 1'b0, 1'b0);
    run_op(mk(3'd0, 8'd6, 8'd7, 8'd8), 1'b0, 1'b0);
    chk("error_cleared", 256'(ifc.error), 256'd0);
    @(negedge clk);

    // start pulsed every cycle during an ADD, then held into DONE for a back-to-back op
    run_op(mk(3'd0, 8'd1, 8'd2, 8'd20), 1'b1, 1'b0);
    run_op(mk(3'd3, 8'd20, 8'd2, 8'd21), 1'b0, 1'b0);
    @(negedge clk);

    // Randomized instruction stream with address collisions
    for (int n = 0; n < 40; n++) begin
      op   = 3'($urandom_range(0, 7));
      spam = ($urandom_range(0, 3) == 0);
      b2b  = ($urandom_range(0, 1) == 1);
      run_op(mk(op, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))), spam, 1'b0);
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);

    // Reset in the WRITE cycle: single-edge write lands, outputs clear, no done
    run_op(mk(3'd0, 8'd1, 8'd2, 8'd30), 1'b0, 1'b1);
    chk("abort_in_write", 256'(ifc.mem_wren), 256'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 256'(ifc.done), 256'd0);

    // Recovery
    run_op(mk(3'd2, 8'd30, 8'd2, 8'd31), 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    chk("scoreboard_drained", 256'(sb_q.size()), 256'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) bad++;
    chk("ram_final_image", 256'(bad), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
